mod_exp_decryptor: RTL and testbench
====================================

MOD_EXP_DECRYPTOR -- requirements
Module: mod_exp_decryptor

Interface
REQ-001 SHALL have parameter KEYSIZE, default 12: private exponent width in bits.
REQ-002 SHALL have parameter MODSIZE, default 12: modulus, cipher and message width in bits, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have port privKey, input, KEYSIZE bits: exponent d.
REQ-008 SHALL have port cipher, input, MODSIZE bits: ciphertext c.
REQ-009 SHALL have port modulos, input, MODSIZE bits: modulus n.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port msg, output, MODSIZE bits: result, c^d mod n.
REQ-013 SHALL have port err, output, 1 bit: the request had modulos==0.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid&&in_ready, registering privKey, cipher and modulos; inputs outside that edge are ignored.
REQ-015 SHALL drive in_ready=1 only in IDLE; in_valid in any other state is ignored and has no side effects.
REQ-016 SHALL use states IDLE, REDUCE, SQUARE, MULT, DONE: IDLE->REDUCE on accept; REDUCE->SQUARE; SQUARE->MULT; MULT->SQUARE while exponent bits remain, else ->DONE; DONE->IDLE on out_ready.
REQ-017 SHALL in REDUCE compute base = cipher mod n as cipher*1 mod n, so cipher>=n is legal; accumulator initialised to 1 mod n.
REQ-018 SHALL scan privKey MSB to LSB, left-to-right: SQUARE acc=acc*acc mod n; MULT computes acc*base mod n every bit, kept only if the bit is 1, giving constant time independent of the key.
REQ-019 SHALL perform each modular multiply by interleaved shift-add over MODSIZE multiplier bits, MSB first: P=2P+b_i*A, then at most two conditional subtractions of n; intermediate width MODSIZE+2; operands are always <n.
REQ-020 SHALL make each modular multiply take exactly MODSIZE+2 cycles: 1 load, MODSIZE iterate, 1 finish.
REQ-021 SHALL assert out_valid exactly L=(2*KEYSIZE+1)*(MODSIZE+2)+1 cycles after the accepting edge when modulos!=0.
REQ-022 SHALL, when modulos==0, skip REDUCE/SQUARE/MULT, assert out_valid the cycle after acceptance with err=1 and msg=0.
REQ-023 SHALL give msg=0 when modulos==1 and msg=1 when privKey==0 with n>1, both at normal latency L.
REQ-024 SHALL hold msg, err and out_valid stable in DONE until out_ready=1; out_valid falls on the edge where out_valid&&out_ready; in_ready rises that same edge.
REQ-025 SHALL not accept a new request in the same cycle the result is consumed; the next accept is at the earliest one cycle later.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-operation, immediately force state IDLE, out_valid=0, err=0, msg=0, clear all datapath registers, and abandon any in-flight computation without producing a result.
REQ-027 SHALL hold in_ready=0 while rst_n is low and drive in_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-028 SHALL place the FSM state enumeration and the latency formula constant in a shared package, decryptor_pkg.
REQ-029 SHALL implement the modular multiplier as sub-module mod_mul (MODSIZE parameter, start/done handshake, operands A, B, n), instantiated once and time-shared across REDUCE, SQUARE and MULT.

Verification
REQ-030 SHALL cover the RSA vector: KEYSIZE=12, MODSIZE=12, privKey=2753, cipher=2790, modulos=3233, out_ready=1 -> msg=65, err=0, out_valid at cycle 351 after acceptance.
REQ-031 SHALL cover modulus zero: modulos=0 -> out_valid one cycle after acceptance, err=1, msg=0.
REQ-032 SHALL cover degenerate cases: privKey=0, cipher=2790, modulos=3233 -> msg=1; modulos=1 -> msg=0; both at cycle 351.
REQ-033 SHALL cover backpressure: RSA vector with out_ready low for 5 cycles after out_valid -> msg=65 held stable, in_ready=0, and a second in_valid presented during this window is not accepted.
REQ-034 SHALL cover reset mid-operation: rst_n pulsed low at cycle 100 of the RSA vector -> outputs zero immediately, in_ready=1 after release, no out_valid; a new request then gives msg=65 at cycle 351.
REQ-035 SHALL cover cipher>=n: cipher=3233+7 with MODSIZE=13, KEYSIZE=12, modulos=3233, privKey=2 -> msg=49.

Source files
------------

// File: rtl/decryptor_pkg.sv
// Shared types and timing helpers for the modular-exponentiation decryptor.
package decryptor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    SQUARE = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Cycles from the accepting edge to out_valid for a nonzero modulus.
  function automatic int latency(input int keysize, input int modsize);
    return (2 * keysize + 1) * (modsize + 2) + 1;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier: p = a*b mod n in MODSIZE+2 cycles
// (load, MODSIZE iterations, done). Operand a must be below 3n - 2p headroom.
module mod_mul #(
  parameter int MODSIZE = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MODSIZE-1:0] a,
  input  logic [MODSIZE-1:0] b,
  input  logic [MODSIZE-1:0] n,
  output logic               done,
  output logic [MODSIZE-1:0] p
);

  localparam int W  = MODSIZE + 2;
  localparam int CW = $clog2(MODSIZE + 1);

  logic [MODSIZE-1:0] a_r, b_r, n_r;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [W-1:0]       sum, s1, s2, nn;

  // 2p + b_i*a stays below 3n, so two conditional subtractions always suffice.
  always_comb begin
    nn  = {2'b00, n_r};
    sum = {1'b0, p, 1'b0} + (b_r[MODSIZE-1] ? {2'b00, a_r} : '0);
    s1  = (sum >= nn) ? sum - nn : sum;
    s2  = (s1 >= nn) ? s1 - nn : s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      n_r  <= '0;
      p    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r  <= a;
        b_r  <= b;
        n_r  <= n;
        p    <= '0;
        cnt  <= CW'(MODSIZE);
        busy <= 1'b1;
      end else if (busy) begin
        p   <= s2[MODSIZE-1:0];
        b_r <= {b_r[MODSIZE-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_exp_decryptor.sv
// Left-to-right square-and-always-multiply exponentiation c^d mod n,
// time-sharing one mod_mul across the reduce, square and multiply steps.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// REDUCE | base = cipher*1 mod n
// SQUARE | acc = acc*acc mod n
// MULT   | acc*base mod n, kept only when the key bit is 1
// DONE   | result presented, held until out_ready
module mod_exp_decryptor
  import decryptor_pkg::*;
#(
  parameter int KEYSIZE = 12,
  parameter int MODSIZE = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KEYSIZE-1:0] privKey,
  input  logic [MODSIZE-1:0] cipher,
  input  logic [MODSIZE-1:0] modulos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MODSIZE-1:0] msg,
  output logic               err
);

  localparam int IW = (KEYSIZE > 1) ? $clog2(KEYSIZE) : 1;

  state_t             state;
  logic [KEYSIZE-1:0] key_r;
  logic [MODSIZE-1:0] cipher_r, n_r, base, acc;
  logic [IW-1:0]      idx;
  logic               mul_start, mul_done;
  logic [MODSIZE-1:0] mul_a, mul_b, mul_p;

  assign in_ready = rst_n && (state == IDLE);

  always_comb begin
    mul_a = MODSIZE'(1);
    mul_b = cipher_r;
    case (state)
      SQUARE: begin
        mul_a = acc;
        mul_b = acc;
      end
      MULT: begin
        mul_a = acc;
        mul_b = base;
      end
      default: ;
    endcase
  end

  mod_mul #(.MODSIZE(MODSIZE)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .n     (n_r),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_r     <= '0;
      cipher_r  <= '0;
      n_r       <= '0;
      base      <= '0;
      acc       <= '0;
      idx       <= '0;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
      msg       <= '0;
      err       <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            key_r    <= privKey;
            cipher_r <= cipher;
            n_r      <= modulos;
            idx      <= IW'(KEYSIZE - 1);
            acc      <= (modulos > MODSIZE'(1)) ? MODSIZE'(1) : '0;
            if (modulos == '0) begin
              state <= DONE;
            end else begin
              state     <= REDUCE;
              mul_start <= 1'b1;
            end
          end
        end
        REDUCE: begin
          if (mul_done) begin
            base      <= mul_p;
            state     <= SQUARE;
            mul_start <= 1'b1;
          end
        end
        SQUARE: begin
          if (mul_done) begin
            acc       <= mul_p;
            state     <= MULT;
            mul_start <= 1'b1;
          end
        end
        MULT: begin
          if (mul_done) begin
            if (key_r[idx]) acc <= mul_p;
            if (idx == '0) begin
              state <= DONE;
            end else begin
              idx       <= idx - 1'b1;
              state     <= SQUARE;
              mul_start <= 1'b1;
            end
          end
        end
        DONE: begin
          // One registration cycle before out_valid rises keeps latency at L.
          if (!out_valid) begin
            out_valid <= 1'b1;
            err       <= (n_r == '0);
            msg       <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_decryptor.sv
// Directed bench for mod_exp_decryptor: RSA vector, degenerate moduli/keys,
// backpressure, mid-operation reset and an oversized cipher on a 13-bit build.
module tb_mod_exp_decryptor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [11:0] priv_key, cipher, modulos, msg;

  logic        in_valid13, in_ready13, out_valid13, out_ready13, err13;
  logic [11:0] priv_key13;
  logic [12:0] cipher13, modulos13, msg13;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc;
  bit ov_seen;

  always #5 clk = ~clk;

  mod_exp_decryptor #(.KEYSIZE(12), .MODSIZE(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .privKey(priv_key), .cipher(cipher), .modulos(modulos),
    .out_valid(out_valid), .out_ready(out_ready), .msg(msg), .err(err)
  );

  mod_exp_decryptor #(.KEYSIZE(12), .MODSIZE(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready13),
    .privKey(priv_key13), .cipher(cipher13), .modulos(modulos13),
    .out_valid(out_valid13), .out_ready(out_ready13), .msg(msg13), .err(err13)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic accept(input logic [11:0] k, input logic [11:0] c, input logic [11:0] n);
    priv_key = k;
    cipher   = c;
    modulos  = n;
    in_valid = 1'b1;
    check("accept_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    priv_key = '0; cipher = '0; modulos = '0;
    in_valid13 = 1'b0; out_ready13 = 1'b1;
    priv_key13 = '0; cipher13 = '0; modulos13 = '0;

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_msg", msg, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_in_ready13", in_ready13, 1);
    @(posedge clk);
    #1;

    // RSA vector
    accept(12'd2753, 12'd2790, 12'd3233);
    wait_out(cyc);
    check("rsa_latency", cyc, 351);
    check("rsa_msg", msg, 65);
    check("rsa_err", err, 0);
    @(posedge clk);
    #1;
    check("rsa_consumed_ov", out_valid, 0);
    check("rsa_consumed_ir", in_ready, 1);

    // Modulus zero
    accept(12'd2753, 12'd2790, 12'd0);
    wait_out(cyc);
    check("mod0_latency", cyc, 1);
    check("mod0_err", err, 1);
    check("mod0_msg", msg, 0);
    @(posedge clk);
    #1;

    // Key zero
    accept(12'd0, 12'd2790, 12'd3233);
    wait_out(cyc);
    check("key0_latency", cyc, 351);
    check("key0_msg", msg, 1);
    check("key0_err", err, 0);
    @(posedge clk);
    #1;

    // Modulus one
    accept(12'd2753, 12'd2790, 12'd1);
    wait_out(cyc);
    check("mod1_latency", cyc, 351);
    check("mod1_msg", msg, 0);
    @(posedge clk);
    #1;

    // Backpressure with a competing request while the result is held
    out_ready = 1'b0;
    accept(12'd2753, 12'd2790, 12'd3233);
    wait_out(cyc);
    check("bp_latency", cyc, 351);
    priv_key = 12'd5; cipher = 12'd3; modulos = 12'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_msg", msg, 65);
      check("bp_hold_ov", out_valid, 1);
      check("bp_hold_ir", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", out_valid, 0);
    check("bp_release_ir", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_accept_ir", in_ready, 1);
    check("bp_no_accept_ov", out_valid, 0);

    // Reset at cycle 100 of an RSA run
    accept(12'd2753, 12'd2790, 12'd3233);
    repeat (99) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ov", out_valid, 0);
    check("midrst_msg", msg, 0);
    check("midrst_err", err, 0);
    check("midrst_ir", in_ready, 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_release_ir", in_ready, 1);
    ov_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("midrst_no_result", ov_seen, 0);
    accept(12'd2753, 12'd2790, 12'd3233);
    wait_out(cyc);
    check("after_rst_latency", cyc, 351);
    check("after_rst_msg", msg, 65);
    @(posedge clk);
    #1;

    // Cipher above the modulus on the 13-bit build: 3240 = 7 mod 3233, 7^2 = 49
    priv_key13 = 12'd2; cipher13 = 13'd3240; modulos13 = 13'd3233;
    in_valid13 = 1'b1;
    check("c13_in_ready", in_ready13, 1);
    @(posedge clk);
    #1;
    in_valid13 = 1'b0;
    cyc = 0;
    while (!out_valid13 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("c13_latency", cyc, 376);
    check("c13_msg", msg13, 49);
    check("c13_err", err13, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
